// File: rtl/teste.sv
// -----------------------------------------------------------------------------
// teste -- parameterised modulo step counter with registered output.
//
// Counts from START in increments of STEP, wrapping modulo MAX_COUNT+1, either
// up (UP=1) or down (UP=0). The count advances on every rising Clock edge
// while Reset is high; there is no enable.
//
// Optional feature macro: TESTE_GRAY_OUT_EN
//   defined   -> Out carries gray(cnt) = cnt ^ (cnt >> 1)
//   undefined -> Out carries the binary count
//
// Ports:
//   Clock  in   1  single clock, rising-edge active
//   Reset  in   1  asynchronous, active-low reset (loads START)
//   Out    out  4  registered count (binary or Gray), same edge as the count
//
// Parameters:
//   MAX_COUNT  1..15         highest count value
//   STEP       1..MAX_COUNT  increment per clock
//   START      0..MAX_COUNT  value loaded by reset
//   UP         0/1           direction (1 = up)
// -----------------------------------------------------------------------------
module teste #(
  parameter int MAX_COUNT = 15,
  parameter int STEP      = 1,
  parameter int START     = 0,
  parameter int UP        = 1
) (
  input  logic       Clock,
  input  logic       Reset,
  output logic [3:0] Out
);

  // Parameter legality: stop elaboration on any out-of-range value.
  if (MAX_COUNT < 1 || MAX_COUNT > 15) begin : g_bad_max
    $error("teste: MAX_COUNT=%0d outside legal range 1..15", MAX_COUNT);
  end
  if (STEP < 1 || STEP > MAX_COUNT) begin : g_bad_step
    $error("teste: STEP=%0d outside legal range 1..MAX_COUNT", STEP);
  end
  if (START < 0 || START > MAX_COUNT) begin : g_bad_start
    $error("teste: START=%0d outside legal range 0..MAX_COUNT", START);
  end
  if (UP != 0 && UP != 1) begin : g_bad_up
    $error("teste: UP=%0d must be 0 or 1", UP);
  end

  // Next-value arithmetic runs at 5 bits so cnt+STEP (up to 30) and
  // cnt+MAX_COUNT+1 (up to 31) never overflow before the wrap decision.
  localparam logic [4:0] L_MAX   = 5'(MAX_COUNT);
  localparam logic [4:0] L_MOD   = 5'(MAX_COUNT + 1);
  localparam logic [4:0] L_STEP  = 5'(STEP);
  localparam logic [3:0] L_START = 4'(START);

`ifdef TESTE_GRAY_OUT_EN
  localparam logic [3:0] L_RST_OUT = L_START ^ (L_START >> 1);
`else
  localparam logic [3:0] L_RST_OUT = L_START;
`endif

  logic [3:0] r_cnt;
  logic [3:0] r_out;
  logic [4:0] w_cnt5;
  logic [4:0] w_sum5;
  logic [3:0] w_next;
  logic [3:0] w_next_out;

  assign w_cnt5 = {1'b0, r_cnt};
  assign w_sum5 = w_cnt5 + L_STEP;

  // Wrap selection. Both branches stay inside 0..MAX_COUNT, so the low four
  // bits carry the full result and cnt can never exceed MAX_COUNT.
  always_comb begin
    w_next = '0;
    if (UP != 0) begin
      if (w_sum5 <= L_MAX) begin
        w_next = w_sum5[3:0];
      end else begin
        w_next = 4'(w_sum5 - L_MOD);
      end
    end else begin
      if (w_cnt5 >= L_STEP) begin
        w_next = 4'(w_cnt5 - L_STEP);
      end else begin
        w_next = 4'(w_cnt5 + L_MOD - L_STEP);
      end
    end
  end

  // Out is formed from the next count so it lands on the same edge as cnt
  // with no extra pipeline delay.
`ifdef TESTE_GRAY_OUT_EN
  assign w_next_out = w_next ^ (w_next >> 1);
`else
  assign w_next_out = w_next;
`endif

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_cnt <= L_START;
      r_out <= L_RST_OUT;
    end else begin
      r_cnt <= w_next;
      r_out <= w_next_out;
    end
  end

  assign Out = r_out;

endmodule

// File: tb/tb_teste.sv
// -----------------------------------------------------------------------------
// tb_teste -- self-checking bench for teste. Four instances with different
// parameter sets share Clock and Reset; a modulo-arithmetic reference model
// predicts every output on every edge, including random async reset pulses.
// -----------------------------------------------------------------------------
module tb_teste;

  logic       Clock;
  logic       Reset;
  logic [3:0] out_def;
  logic [3:0] out_m9;
  logic [3:0] out_dn;
  logic [3:0] out_alt;

  int n_checks = 0;
  int n_fail   = 0;

  teste u_def (.Clock(Clock), .Reset(Reset), .Out(out_def));

  teste #(.MAX_COUNT(9), .STEP(3), .START(0), .UP(1))
    u_m9 (.Clock(Clock), .Reset(Reset), .Out(out_m9));

  teste #(.MAX_COUNT(15), .STEP(1), .START(0), .UP(0))
    u_dn (.Clock(Clock), .Reset(Reset), .Out(out_dn));

  teste #(.MAX_COUNT(12), .STEP(5), .START(7), .UP(0))
    u_alt (.Clock(Clock), .Reset(Reset), .Out(out_alt));

  initial Clock = 1'b0;
  always #50 Clock = ~Clock;

  // Reference model: plain modulo arithmetic on integers.
  int m_def, m_m9, m_dn, m_alt;

  function automatic int adv(int c, int mx, int st, int up);
    if (up != 0) return (c + st) % (mx + 1);
    else         return (c - st + mx + 1) % (mx + 1);
  endfunction

  function automatic logic [3:0] enc(int c);
    logic [3:0] b;
    b = 4'(c);
`ifdef TESTE_GRAY_OUT_EN
    return b ^ (b >> 1);
`else
    return b;
`endif
  endfunction

  function automatic int dec(logic [3:0] o);
`ifdef TESTE_GRAY_OUT_EN
    logic [3:0] b;
    b[3] = o[3];
    b[2] = b[3] ^ o[2];
    b[1] = b[2] ^ o[1];
    b[0] = b[1] ^ o[0];
    return int'(b);
`else
    return int'(o);
`endif
  endfunction

  always @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      m_def = 0; m_m9 = 0; m_dn = 0; m_alt = 7;
    end else begin
      m_def = adv(m_def, 15, 1, 1);
      m_m9  = adv(m_m9,   9, 3, 1);
      m_dn  = adv(m_dn,  15, 1, 0);
      m_alt = adv(m_alt, 12, 5, 0);
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    check("def", int'(out_def), int'(enc(m_def)));
    check("m9",  int'(out_m9),  int'(enc(m_m9)));
    check("dn",  int'(out_dn),  int'(enc(m_dn)));
    check("alt", int'(out_alt), int'(enc(m_alt)));
    check("m9_rng",  int'(dec(out_m9)  <= 9),  1);
    check("alt_rng", int'(dec(out_alt) <= 12), 1);
  endtask

  int m9_tab[10] = '{3, 6, 9, 2, 5, 8, 1, 4, 7, 0};
  int dn_tab[3]  = '{15, 14, 13};

  initial begin
    int d;
    Reset = 1'b1;
    #5 Reset = 1'b0;
    #5;
    check("rst_def", int'(out_def), int'(enc(0)));
    check("rst_m9",  int'(out_m9),  int'(enc(0)));
    check("rst_dn",  int'(out_dn),  int'(enc(0)));
    check("rst_alt", int'(out_alt), int'(enc(7)));
    #90 Reset = 1'b1;

    // Directed run from reset release: 36 edges.
    for (int e = 1; e <= 36; e++) begin
      @(posedge Clock); #1;
      check_all();
      if (e <= 10) check("m9_seq", int'(out_m9), int'(enc(m9_tab[e-1])));
      if (e <= 3)  check("dn_seq", int'(out_dn), int'(enc(dn_tab[e-1])));
      if (e == 15) check("def_15", int'(out_def), int'(enc(15)));
      if (e == 16) check("def_wrap", int'(out_def), int'(enc(0)));
      if (e == 36) check("def_36", int'(out_def), int'(enc(4)));
    end

    // Run on to 7, then reset between edges.
    for (int e = 0; e < 3; e++) begin
      @(posedge Clock); #1;
      check_all();
    end
    check("def_7", int'(out_def), int'(enc(7)));
    #20 Reset = 1'b0;
    #1;
    check("rst_async", int'(out_def), int'(enc(0)));
    check_all();
    @(negedge Clock);
    Reset = 1'b1;
    @(posedge Clock); #1;
    check("rel_first", int'(out_def), int'(enc(1)));
    check_all();

    // Randomized phase with async reset pulses and held resets.
    for (int i = 0; i < 400; i++) begin
      @(posedge Clock); #1;
      check_all();
      if ($urandom_range(0, 19) == 0) begin
        d = $urandom_range(10, 40);
        #(d) Reset = 1'b0;
        #1;
        check_all();
        #40 Reset = 1'b1;
      end else if ($urandom_range(0, 39) == 0) begin
        #20 Reset = 1'b0;
        @(posedge Clock); #1;
        check_all();
        #20 Reset = 1'b1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
